// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order allocate / out-of-order complete / in-order retire buffer.
// head_entry packs {valid, dest_reg[4:0], mem_size[MEM_W-1:0], value[31:0], dest_addr[31:0]}.
module reorder_buffer #(
  parameter int ROB_SIZE = 8,
  parameter int TAG_W = $clog2(ROB_SIZE),
  parameter int MEM_W = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               dispatch_valid,
  input  logic [4:0]         dispatch_dest,
  input  logic [MEM_W-1:0]   dispatch_size,
  output logic [TAG_W-1:0]   dispatch_tag,
  output logic               full,
  output logic               empty,
  input  logic               cdb_valid,
  input  logic [TAG_W-1:0]   cdb_tag,
  input  logic [31:0]        cdb_value,
  input  logic [31:0]        cdb_addr,
  output logic [MEM_W+69:0]  head_entry,
  output logic               head_ready
);
  logic [ROB_SIZE-1:0] valid, ready;
  logic [4:0]          dest  [ROB_SIZE];
  logic [MEM_W-1:0]    size  [ROB_SIZE];
  logic [31:0]         value [ROB_SIZE];
  logic [31:0]         addr  [ROB_SIZE];
  logic [TAG_W-1:0]    head, tail;
  logic [TAG_W:0]      count;
  logic                accept, complete;

  assign full         = count == (TAG_W+1)'(ROB_SIZE);
  assign empty        = count == '0;
  assign dispatch_tag = tail;
  assign head_ready   = valid[head] & ready[head];
  assign head_entry   = {valid[head], dest[head], size[head], value[head], addr[head]};
  assign accept       = dispatch_valid & ~full;
  // a completion racing the retire of its own entry is dropped
  assign complete     = cdb_valid & valid[cdb_tag] & ~(head_ready & (cdb_tag == head));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      ready <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        dest[i]  <= '0;
        size[i]  <= '0;
        value[i] <= '0;
        addr[i]  <= '0;
      end
    end else if (flush) begin
      valid <= '0;
      ready <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        dest[i]  <= '0;
        size[i]  <= '0;
        value[i] <= '0;
        addr[i]  <= '0;
      end
    end else begin
      if (complete) begin
        value[cdb_tag] <= cdb_value;
        addr[cdb_tag]  <= cdb_addr;
        ready[cdb_tag] <= 1'b1;
      end
      if (head_ready) begin
        valid[head] <= 1'b0;
        ready[head] <= 1'b0;
        head        <= head + TAG_W'(1);
      end
      // tail slot is free whenever accept is set, so it never aliases head or cdb_tag
      if (accept) begin
        valid[tail] <= 1'b1;
        ready[tail] <= 1'b0;
        dest[tail]  <= dispatch_dest;
        size[tail]  <= dispatch_size;
        value[tail] <= '0;
        addr[tail]  <= '0;
        tail        <= tail + TAG_W'(1);
      end
      count <= count + (TAG_W+1)'(accept) - (TAG_W+1)'(head_ready);
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: program-order queue model feeding a retire scoreboard checked by a monitor.
module tb_reorder_buffer;
  logic        clock = 0, reset = 1, flush = 0, dispatch_valid = 0, cdb_valid = 0, full, empty, head_ready;
  logic [4:0]  dispatch_dest = 0;
  logic [1:0]  dispatch_size = 0;
  logic [2:0]  dispatch_tag, cdb_tag = 0;
  logic [31:0] cdb_value = 0, cdb_addr = 0;
  logic [71:0] head_entry;
  int errors = 0, checks = 0;

  typedef struct {
    int tag;
    logic [4:0] dest;
    logic [1:0] size;
    logic [31:0] value, addr;
    bit done;
  } ent_t;
  ent_t q[$];
  logic [71:0] exp_q[$];
  int tail = 0;

  reorder_buffer dut (
    .clock(clock), .reset(reset), .flush(flush), .dispatch_valid(dispatch_valid),
    .dispatch_dest(dispatch_dest), .dispatch_size(dispatch_size), .dispatch_tag(dispatch_tag),
    .full(full), .empty(empty), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_addr(cdb_addr), .head_entry(head_entry), .head_ready(head_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string n, input logic [71:0] a, input logic [71:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask

  function automatic logic [71:0] pack(input ent_t e);
    return {1'b1, e.dest, e.size, e.value, e.addr};
  endfunction

  task automatic cyc(input bit fl, input bit dv, input logic [4:0] dd, input logic [1:0] ds,
                     input bit cv, input int ct, input logic [31:0] cval, input logic [31:0] caddr);
    bit ret, was_full;
    @(negedge clock);
    check("full", full, q.size() == 8);
    check("empty", empty, q.size() == 0);
    check("dispatch_tag", dispatch_tag, tail);
    check("head_ready", head_ready, q.size() > 0 && q[0].done);
    if (q.size() > 0) check("head_entry", head_entry, pack(q[0]));
    flush = fl; dispatch_valid = dv; dispatch_dest = dd; dispatch_size = ds;
    cdb_valid = cv; cdb_tag = ct[2:0]; cdb_value = cval; cdb_addr = caddr;
    if (fl) begin
      q.delete();
      tail = 0;
    end else begin
      was_full = q.size() == 8;
      ret = q.size() > 0 && q[0].done;
      if (ret) exp_q.push_back(pack(q[0]));
      if (cv)
        for (int i = ret ? 1 : 0; i < q.size(); i++)
          if (q[i].tag == ct) begin
            q[i].value = cval;
            q[i].addr = caddr;
            q[i].done = 1;
          end
      if (ret) void'(q.pop_front());
      if (dv && !was_full) begin
        q.push_back('{tail, dd, ds, 32'h0, 32'h0, 1'b0});
        tail = (tail + 1) % 8;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic disp(input logic [4:0] d);
    cyc(0, 1, d, d[1:0], 0, 0, 0, 0);
  endtask
  task automatic comp(input int t, input logic [31:0] v);
    cyc(0, 0, 0, 0, 1, t, v, v ^ 32'h1000);
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_cyc();
    int ct;
    ct = (q.size() > 0 && $urandom_range(3) != 0) ? q[$urandom_range(q.size() - 1)].tag : $urandom_range(7);
    cyc($urandom_range(49) == 0, $urandom_range(9) < 6, 5'($urandom), 2'($urandom),
        $urandom_range(9) < 6, ct, $urandom, $urandom);
  endtask

  task automatic check_clear(input string n);
    check({n, "_empty"}, empty, 1);
    check({n, "_full"}, full, 0);
    check({n, "_head_ready"}, head_ready, 0);
    check({n, "_head_entry"}, head_entry, 72'h0);
    check({n, "_tag"}, dispatch_tag, 0);
  endtask

  // retire monitor: any head_ready not squashed by flush must match the next expected retire
  initial forever begin
    @(negedge clock);
    #2;
    if (head_ready && !flush) begin
      if (exp_q.size() == 0) check("retire_unexpected", head_entry, 72'h0);
      else check("retire", head_entry, exp_q.pop_front());
    end else if (exp_q.size() > 0) begin
      check("retire_missing", head_ready, 1);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #2;
    check_clear("reset");
    #10 reset = 0;
    for (int i = 0; i < 9; i++) disp(5'(i + 1));
    comp(0, 32'h5);
    cyc(0, 1, 5'd20, 2'd1, 0, 0, 0, 0);
    disp(5'd9);
    comp(1, 32'h7);
    cyc(1, 1, 5'd3, 2'd0, 1, 2, 32'h55, 32'h66);
    check_clear("flush");
    for (int i = 0; i < 3; i++) disp(5'(i + 4));
    comp(2, 32'h2);
    comp(0, 32'hA);
    idle();
    idle();
    comp(1, 32'hB);
    idle();
    idle();
    idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    disp(5'd7);
    comp(0, 32'h1);
    comp(0, 32'hBAD);
    comp(5, 32'h77);
    for (int i = 0; i < 6; i++) disp(5'(i + 10));
    for (int i = 0; i < 2000; i++) rand_cyc();
    for (int i = 0; i < 6; i++) disp(5'(i));
    comp(q[0].tag, 32'hC0FFEE);
    #1 reset = 1;
    #1;
    check_clear("async_reset");
    q.delete();
    tail = 0;
    #2 reset = 0;
    for (int i = 0; i < 300; i++) rand_cyc();
    @(negedge clock);
    #3;
    check("scoreboard_drained", 72'(exp_q.size()), 72'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
